// File: rtl/fp_operand_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// fp_seq_pkg : shared types and constants for the FP operand sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fp_seq_pkg;

  typedef enum logic [2:0] {
    S_COLLECT    = 3'd0,
    S_ARM        = 3'd1,
    S_WAIT_EQ    = 3'd2,
    S_WAIT_CHECK = 3'd3,
    S_HOLD       = 3'd4
  } seq_state_t;

  // Adder qual_lugar phase codes
  localparam logic [2:0] QL_READ  = 3'd0;
  localparam logic [2:0] QL_EQ    = 3'd1;
  localparam logic [2:0] QL_OP    = 3'd2;
  localparam logic [2:0] QL_POS   = 3'd3;
  localparam logic [2:0] QL_CHECK = 3'd4;
  localparam logic [2:0] QL_FIN   = 3'd5;

  // Adder status codes, plus the sequencer's own timeout marker
  localparam logic [3:0] ST_EXACT   = 4'h0;
  localparam logic [3:0] ST_OVF     = 4'h1;
  localparam logic [3:0] ST_UNF     = 4'h2;
  localparam logic [3:0] ST_INEXACT = 4'h3;
  localparam logic [3:0] ST_TIMEOUT = 4'hF;

  localparam int C_BYTES_PER_PAIR = 8;

  function automatic logic is_busy_state(input seq_state_t s);
    return (s == S_ARM) || (s == S_WAIT_EQ) || (s == S_WAIT_CHECK) || (s == S_HOLD);
  endfunction

  function automatic logic is_timed_state(input seq_state_t s);
    return (s == S_ARM) || (s == S_WAIT_EQ) || (s == S_WAIT_CHECK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_operand_sequencer_if.sv
// ----------------------------------------------------------------------------
// fp_seq_if : byte stream, adder link and result handshake of the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fp_seq_if;

  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_A_out;
  logic [31:0] op_B_out;
  logic [2:0]  qual_lugar_in;
  logic [31:0] data_in;
  logic [3:0]  status_in;
  logic [31:0] res_data;
  logic [3:0]  res_status;
  logic        res_timeout;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  // master: byte producer, adder and result consumer; slave: the sequencer
  modport master (
    output in_byte, in_valid, qual_lugar_in, data_in, status_in, res_ready,
    input  in_ready, op_A_out, op_B_out, res_data, res_status, res_timeout,
           res_valid, busy
  );

  modport slave (
    input  in_byte, in_valid, qual_lugar_in, data_in, status_in, res_ready,
    output in_ready, op_A_out, op_B_out, res_data, res_status, res_timeout,
           res_valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/fp_operand_sequencer_packer.sv
// ----------------------------------------------------------------------------
// fp_operand_packer : shifts 8 stream bytes into an A/B operand pair
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_operand_packer
  import fp_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        done,
  output logic [63:0] pair
);

  localparam logic [2:0] C_LAST_IDX = 3'(C_BYTES_PER_PAIR - 1);

  logic [2:0]  r_count;
  // Only 7 bytes are stored; the 8th completes the 64-bit pair combinationally
  logic [55:0] r_shadow;

  assign done = accept && (r_count == C_LAST_IDX);
  assign pair = {r_shadow, byte_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 3'd0;
      r_shadow <= 56'd0;
    end else if (accept) begin
      r_shadow <= {r_shadow[47:0], byte_in};
      r_count  <= done ? 3'd0 : r_count + 3'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_operand_sequencer.sv
// ----------------------------------------------------------------------------
// fp_operand_sequencer : feeds operand pairs to the FP adder, collects results
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_operand_sequencer
  import fp_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock_100kHz,
  input  logic       reset,
  fp_seq_if.slave    bus
);

  localparam int              C_TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [C_TW-1:0] C_TMO_LAST = C_TW'(TIMEOUT_CYCLES - 1);

  seq_state_t r_state;
  seq_state_t w_next;

  logic            w_accept;
  logic            w_done;
  logic [63:0]     w_pair;
  logic [31:0]     r_op_a;
  logic [31:0]     r_op_b;
  logic [2:0]      r_prev_ql;
  logic [C_TW-1:0] r_tmo_cnt;
  logic [31:0]     r_res_data;
  logic [3:0]      r_res_status;
  logic            r_res_timeout;
  logic            r_res_valid;
  logic            w_eq_edge;
  logic            w_timed;
  logic            w_capture;
  logic            w_timeout;
  logic            w_release;

  assign w_accept  = bus.in_valid && (r_state == S_COLLECT);
  assign w_timed   = is_timed_state(r_state);
  // A fresh pass starts only on the rising edge into EQUALIZING
  assign w_eq_edge = (bus.qual_lugar_in == QL_EQ) && (r_prev_ql != QL_EQ);

  fp_operand_packer u_packer (
    .clk     (clock_100kHz),
    .rst     (reset),
    .accept  (w_accept),
    .byte_in (bus.in_byte),
    .done    (w_done),
    .pair    (w_pair)
  );

  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_done) w_next = S_ARM;
      end
      S_ARM: begin
        w_next = S_WAIT_EQ;
      end
      S_WAIT_EQ: begin
        if (w_eq_edge) w_next = S_WAIT_CHECK;
      end
      S_WAIT_CHECK: begin
        if (bus.qual_lugar_in == QL_CHECK) begin
          w_capture = 1'b1;
          w_next    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_res_valid && bus.res_ready) begin
          w_release = 1'b1;
          w_next    = S_COLLECT;
        end
      end
      default: begin
        w_next = S_COLLECT;
      end
    endcase
    // A real capture on the last allowed cycle beats the timeout
    if (w_timed && !w_capture && (r_tmo_cnt == C_TMO_LAST)) begin
      w_timeout = 1'b1;
      w_next    = S_HOLD;
    end
  end

  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      r_prev_ql <= QL_READ;
      r_tmo_cnt <= '0;
      r_op_a    <= 32'd0;
      r_op_b    <= 32'd0;
    end else begin
      r_prev_ql <= bus.qual_lugar_in;
      if (w_done) begin
        r_tmo_cnt <= '0;
      end else if (w_timed) begin
        r_tmo_cnt <= r_tmo_cnt + C_TW'(1);
      end
      if (w_done) begin
        r_op_a <= w_pair[63:32];
        r_op_b <= w_pair[31:0];
      end
    end
  end

  always_ff @(posedge clock_100kHz or posedge reset) begin
    if (reset) begin
      r_res_data    <= 32'd0;
      r_res_status  <= ST_EXACT;
      r_res_timeout <= 1'b0;
      r_res_valid   <= 1'b0;
    end else if (w_capture) begin
      r_res_data    <= bus.data_in;
      r_res_status  <= bus.status_in;
      r_res_timeout <= 1'b0;
      r_res_valid   <= 1'b1;
    end else if (w_timeout) begin
      r_res_data    <= 32'd0;
      r_res_status  <= ST_TIMEOUT;
      r_res_timeout <= 1'b1;
      r_res_valid   <= 1'b1;
    end else if (w_release) begin
      r_res_valid   <= 1'b0;
    end
  end

  assign bus.in_ready    = (r_state == S_COLLECT);
  assign bus.op_A_out    = r_op_a;
  assign bus.op_B_out    = r_op_b;
  assign bus.res_data    = r_res_data;
  assign bus.res_status  = r_res_status;
  assign bus.res_timeout = r_res_timeout;
  assign bus.res_valid   = r_res_valid;
  assign bus.busy        = is_busy_state(r_state);

endmodule

`default_nettype wire
